// File: rtl/mm_test_sequencer.sv
// Campaign controller: launches enabled sub-tests one at a time, watches each with a
// timeout, and tallies pass/fail/timeout. Optional macro: MM_SEQ_STOP_ON_FAIL_EN.
module mm_test_sequencer #(
  parameter int NUM_TESTS      = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int NW = $clog2(NUM_TESTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_i,
  input  logic [NUM_TESTS-1:0] test_en_i,
  input  logic [NUM_TESTS-1:0] test_done_i,
  input  logic [NUM_TESTS-1:0] test_pass_i,
  output logic [NUM_TESTS-1:0] test_start_o,
  output logic                 busy_o,
  output logic                 campaign_done_o,
  output logic [CW-1:0]        current_test_o,
  output logic [NW-1:0]        pass_count_o,
  output logic [NW-1:0]        fail_count_o,
  output logic [NW-1:0]        timeout_count_o,
  output logic [NUM_TESTS-1:0] result_vec_o
);

  // The pointer must be able to hold NUM_TESTS (one past the last index).
  localparam int PW = NW;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_RECORD,
    S_FINISH
  } state_e;

  state_e               state_q,   state_d;
  logic [NUM_TESTS-1:0] en_q,      en_d;
  logic [PW-1:0]        ptr_q,     ptr_d;
  logic [CW-1:0]        idx_q,     idx_d;
  logic [TW-1:0]        timer_q,   timer_d;
  logic                 vpass_q,   vpass_d;
  logic                 vtout_q,   vtout_d;
  logic [NUM_TESTS-1:0] start_q,   start_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [NW-1:0]        pass_q,    pass_d;
  logic [NW-1:0]        fail_q,    fail_d;
  logic [NW-1:0]        tout_q,    tout_d;
  logic [NUM_TESTS-1:0] result_q,  result_d;

  logic                 sel_found;
  logic [CW-1:0]        sel_idx;
  logic                 stop_now;

  // Lowest enabled index at or above the pointer; scanning downward leaves the lowest hit.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (en_q[i] && (i >= int'(ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
  end

`ifdef MM_SEQ_STOP_ON_FAIL_EN
  assign stop_now = !vpass_q || vtout_q;
`else
  assign stop_now = 1'b0;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    vpass_d  = vpass_q;
    vtout_d  = vtout_q;
    start_d  = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tout_d   = tout_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          en_d     = test_en_i;
          pass_d   = '0;
          fail_d   = '0;
          tout_d   = '0;
          result_d = '0;
          busy_d   = 1'b1;
          ptr_d    = '0;
          state_d  = S_SELECT;
        end
      end
      // Outputs are registered, so the launch pulse and index are loaded on entry to LAUNCH.
      S_SELECT: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          timer_d = '0;
          start_d = NUM_TESTS'(1) << sel_idx;
          state_d = S_LAUNCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (test_done_i[idx_q]) begin
          vpass_d = test_pass_i[idx_q];
          vtout_d = 1'b0;
          state_d = S_RECORD;
        end else if (timer_q == TIMER_LAST) begin
          vpass_d = 1'b0;
          vtout_d = 1'b1;
          state_d = S_RECORD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RECORD: begin
        if (vtout_q) begin
          tout_d = tout_q + NW'(1);
        end else if (vpass_q) begin
          pass_d          = pass_q + NW'(1);
          result_d[idx_q] = 1'b1;
        end else begin
          fail_d = fail_q + NW'(1);
        end
        ptr_d = PW'(idx_q) + PW'(1);
        if (stop_now) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_SELECT;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      vpass_q  <= 1'b0;
      vtout_q  <= 1'b0;
      start_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      tout_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      vpass_q  <= vpass_d;
      vtout_q  <= vtout_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tout_q   <= tout_d;
      result_q <= result_d;
    end
  end

  assign test_start_o    = start_q;
  assign busy_o          = busy_q;
  assign campaign_done_o = done_q;
  assign current_test_o  = idx_q;
  assign pass_count_o    = pass_q;
  assign fail_count_o    = fail_q;
  assign timeout_count_o = tout_q;
  assign result_vec_o    = result_q;

endmodule

// File: tb/tb_mm_test_sequencer.sv
// Scoreboard bench for mm_test_sequencer: stimulus pushes expected launches and campaign
// results; a monitor pops and compares on every start pulse and completion pulse.
module tb_mm_test_sequencer;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int CW = 2;
  localparam int NW = 3;

  typedef enum int {M_PASS, M_FAIL, M_NEVER} mode_e;
  typedef struct {
    int           pass;
    int           fail;
    int           tout;
    logic [N-1:0] vec;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_i;
  logic [N-1:0]  test_en_i;
  logic [N-1:0]  test_done_i;
  logic [N-1:0]  test_pass_i;
  logic [N-1:0]  test_start_o;
  logic          busy_o;
  logic          campaign_done_o;
  logic [CW-1:0] current_test_o;
  logic [NW-1:0] pass_count_o;
  logic [NW-1:0] fail_count_o;
  logic [NW-1:0] timeout_count_o;
  logic [N-1:0]  result_vec_o;

  mm_test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_i           (run_i),
    .test_en_i       (test_en_i),
    .test_done_i     (test_done_i),
    .test_pass_i     (test_pass_i),
    .test_start_o    (test_start_o),
    .busy_o          (busy_o),
    .campaign_done_o (campaign_done_o),
    .current_test_o  (current_test_o),
    .pass_count_o    (pass_count_o),
    .fail_count_o    (fail_count_o),
    .timeout_count_o (timeout_count_o),
    .result_vec_o    (result_vec_o)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    done_cnt = 0;
  int    start_cnt = 0;
  int    start_cycle[N];
  int    done_cycle = 0;
  int    exp_start_q[$];
  res_t  exp_res_q[$];
  mode_e mode[N];

  int    mon_idx;
  res_t  mon_res;
  int    rsp_idx;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares on launch pulses and completion pulses.
  initial forever begin
    @(negedge clk);
    if (|test_start_o) begin
      mon_idx = 0;
      for (int i = 0; i < N; i++) if (test_start_o[i]) mon_idx = i;
      check("start_onehot", 64'($countones(test_start_o)), 64'd1);
      if (exp_start_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got index %0d expected no launch", mon_idx);
      end else begin
        check("start_index", 64'(mon_idx), 64'(exp_start_q.pop_front()));
      end
      check("current_test", 64'(current_test_o), 64'(mon_idx));
      start_cycle[mon_idx] = cycle;
      start_cnt++;
    end
    if (campaign_done_o) begin
      done_cnt++;
      done_cycle = cycle;
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got completion pulse expected none");
      end else begin
        mon_res = exp_res_q.pop_front();
        check("pass_count",    64'(pass_count_o),    64'(mon_res.pass));
        check("fail_count",    64'(fail_count_o),    64'(mon_res.fail));
        check("timeout_count", 64'(timeout_count_o), 64'(mon_res.tout));
        check("result_vec",    64'(result_vec_o),    64'(mon_res.vec));
        check("busy_at_done",  64'(busy_o),          64'd1);
      end
    end
  end

  // Sub-test model: answers a launch 3 cycles later according to its mode.
  initial begin
    test_done_i = '0;
    test_pass_i = '0;
    forever begin
      @(posedge clk);
      #1;
      test_done_i = '0;
      if (|test_start_o) begin
        rsp_idx = 0;
        for (int i = 0; i < N; i++) if (test_start_o[i]) rsp_idx = i;
        if (mode[rsp_idx] != M_NEVER) begin
          repeat (3) @(posedge clk);
          #1;
          test_pass_i[rsp_idx] = (mode[rsp_idx] == M_PASS);
          test_done_i[rsp_idx] = 1'b1;
        end
      end
    end
  end

  task automatic set_modes(input mode_e m0, input mode_e m1, input mode_e m2, input mode_e m3);
    mode[0] = m0;
    mode[1] = m1;
    mode[2] = m2;
    mode[3] = m3;
  endtask

  task automatic push_starts(input logic [N-1:0] list);
    for (int i = 0; i < N; i++) if (list[i]) exp_start_q.push_back(i);
  endtask

  task automatic push_res(input int p, input int f, input int t, input logic [N-1:0] v);
    res_t r;
    r.pass = p;
    r.fail = f;
    r.tout = t;
    r.vec  = v;
    exp_res_q.push_back(r);
  endtask

  task automatic do_run(input logic [N-1:0] mask);
    @(posedge clk);
    #1;
    test_en_i = mask;
    run_i     = 1'b1;
    @(posedge clk);
    #1;
    run_i     = 1'b0;
    test_en_i = '0;
    check("busy_after_run", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_campaign(input string name);
    int base;
    int n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_completed"}, 64'(done_cnt), 64'(base + 1));
    repeat (3) @(posedge clk);
    #1;
    check({name, "_busy_cleared"}, 64'(busy_o), 64'd0);
    check({name, "_single_done"}, 64'(done_cnt), 64'(base + 1));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_start"},   64'(test_start_o),    64'd0);
    check({name, "_busy"},    64'(busy_o),          64'd0);
    check({name, "_done"},    64'(campaign_done_o), 64'd0);
    check({name, "_current"}, 64'(current_test_o),  64'd0);
    check({name, "_pass"},    64'(pass_count_o),    64'd0);
    check({name, "_fail"},    64'(fail_count_o),    64'd0);
    check({name, "_timeout"}, 64'(timeout_count_o), 64'd0);
    check({name, "_vec"},     64'(result_vec_o),    64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int base_starts;
    int base_done;
    int n;
    rst_n     = 1'b0;
    run_i     = 1'b0;
    test_en_i = '0;
    set_modes(M_PASS, M_PASS, M_PASS, M_PASS);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy_o), 64'd0);

    // All four enabled and passing; a run_i pulse mid-campaign must change nothing.
    push_starts(4'b1111);
    push_res(4, 0, 0, 4'b1111);
    do_run(4'b1111);
    repeat (3) @(posedge clk);
    #1;
    run_i     = 1'b1;
    test_en_i = 4'b0001;
    @(posedge clk);
    #1;
    run_i     = 1'b0;
    test_en_i = '0;
    wait_campaign("all_pass");
    check("pass_gap", 64'(start_cycle[1] - start_cycle[0]), 64'd6);
    check("hold_pass_count", 64'(pass_count_o), 64'd4);

    // Sparse mask.
    push_starts(4'b1010);
    push_res(2, 0, 0, 4'b1010);
    do_run(4'b1010);
    wait_campaign("mask_1010");

    // Test 2 never answers.
    set_modes(M_PASS, M_PASS, M_NEVER, M_PASS);
`ifdef MM_SEQ_STOP_ON_FAIL_EN
    push_starts(4'b0111);
    push_res(2, 0, 1, 4'b0011);
`else
    push_starts(4'b1111);
    push_res(3, 0, 1, 4'b1011);
`endif
    do_run(4'b1111);
    wait_campaign("timeout");
`ifdef MM_SEQ_STOP_ON_FAIL_EN
    check("timeout_gap", 64'(done_cycle - start_cycle[2]), 64'(T + 2));
`else
    check("timeout_gap", 64'(start_cycle[3] - start_cycle[2]), 64'(T + 3));
`endif

    // Test 1 reports fail.
    set_modes(M_PASS, M_FAIL, M_PASS, M_PASS);
`ifdef MM_SEQ_STOP_ON_FAIL_EN
    push_starts(4'b0011);
    push_res(1, 1, 0, 4'b0001);
`else
    push_starts(4'b1111);
    push_res(3, 1, 0, 4'b1101);
`endif
    do_run(4'b1111);
    wait_campaign("fail");

    // Reset during WAIT of test 1: outputs drop at once, no completion follows.
    set_modes(M_PASS, M_PASS, M_PASS, M_PASS);
    push_starts(4'b0011);
    base_starts = start_cnt;
    base_done   = done_cnt;
    do_run(4'b1111);
    n = 0;
    while (start_cnt < base_starts + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reset_mid_reached_test1", 64'(start_cnt), 64'(base_starts + 2));
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("reset_mid_no_done", 64'(done_cnt), 64'(base_done));
    check("reset_mid_idle", 64'(busy_o), 64'd0);

    // Empty mask completes with zero counters.
    push_res(0, 0, 0, 4'b0000);
    do_run(4'b0000);
    wait_campaign("empty");

    check("starts_drained", 64'(exp_start_q.size()), 64'd0);
    check("results_drained", 64'(exp_res_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
